// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: operand width, alufn field positions and
// compare-unit encodings carried on alufn[2:1].
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned ALUFN_W       = 6;
    localparam int unsigned ALUFN_SUB_BIT = 0;
    localparam int unsigned CLA_GROUP_W   = 4;

    localparam logic [1:0] CMP_EQ = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_LE = 2'b11;

    // Compare-unit selector lives on alufn[2:1]
    function automatic logic [1:0] alufn_cmp_field(input logic [ALUFN_W-1:0] fn);
        return fn[2:1];
    endfunction

endpackage

// File: rtl/add_sub_cla_adder.sv
// WIDTH-bit carry-lookahead adder built from 4-bit lookahead groups chained
// through group generate/propagate. WIDTH must be a multiple of 4.
module cla_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bx,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    localparam int unsigned NUM_GROUPS = WIDTH / CLA_GROUP_W;

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;

    assign w_g = a & bx;
    assign w_p = a ^ bx;

    // Per-group lookahead carries; group carry-out from group G/P
    always_comb begin
        logic       v_cg;
        logic [3:0] v_g;
        logic [3:0] v_p;
        logic       v_gg;
        logic       v_gp;
        w_c  = '0;
        v_cg = cin;
        v_g  = '0;
        v_p  = '0;
        v_gg = 1'b0;
        v_gp = 1'b0;
        for (int grp = 0; grp < int'(NUM_GROUPS); grp++) begin
            v_g = w_g[grp*4 +: 4];
            v_p = w_p[grp*4 +: 4];
            w_c[grp*4]     = v_cg;
            w_c[grp*4 + 1] = v_g[0] | (v_p[0] & v_cg);
            w_c[grp*4 + 2] = v_g[1] | (v_p[1] & v_g[0]) | (v_p[1] & v_p[0] & v_cg);
            w_c[grp*4 + 3] = v_g[2] | (v_p[2] & v_g[1]) | (v_p[2] & v_p[1] & v_g[0])
                           | (v_p[2] & v_p[1] & v_p[0] & v_cg);
            v_gg = v_g[3] | (v_p[3] & v_g[2]) | (v_p[3] & v_p[2] & v_g[1])
                 | (v_p[3] & v_p[2] & v_p[1] & v_g[0]);
            v_gp = &v_p;
            v_cg = v_gg | (v_gp & v_cg);
        end
        w_c[WIDTH] = v_cg;
    end

    assign sum   = w_p ^ w_c[WIDTH-1:0];
    assign cout  = w_c[WIDTH];
    assign c_msb = w_c[WIDTH-1];

endmodule

// File: rtl/add_sub.sv
// Registered 32-bit two's-complement adder/subtractor with Z/V/N flags;
// alufn[0] selects subtract, the remaining alufn bits are not decoded here.
module add_sub
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ALUFN_W-1:0] alufn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   s,
    output logic               z,
    output logic               v,
    output logic               n
);

    logic             w_sub;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb;
    logic             w_z;
    logic             w_v;
    logic             w_n;
    logic             w_unused_alufn;

    logic [WIDTH-1:0] r_s;
    logic             r_z;
    logic             r_v;
    logic             r_n;

    assign w_sub          = alufn[ALUFN_SUB_BIT];
    assign w_bx           = b ^ {WIDTH{w_sub}};
    assign w_unused_alufn = ^alufn[ALUFN_W-1:1];

    cla_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .a     (a),
        .bx    (w_bx),
        .cin   (w_sub),
        .sum   (w_sum),
        .cout  (w_cout),
        .c_msb (w_c_msb)
    );

    // Signed overflow: carry into the sign bit disagrees with carry out of it
    assign w_v = w_cout ^ w_c_msb;
    assign w_z = ~|w_sum;
    assign w_n = w_sum[WIDTH-1];

    // Reset overrides any operand values, so X operands never reach the outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s <= '0;
            r_z <= 1'b0;
            r_v <= 1'b0;
            r_n <= 1'b0;
        end else begin
            r_s <= w_sum;
            r_z <= w_z;
            r_v <= w_v;
            r_n <= w_n;
        end
    end

    assign s = r_s;
    assign z = r_z;
    assign v = r_v;
    assign n = r_n;

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed vector table, reset and
// back-to-back sequences, and random operations against an arithmetic model.
module tb_add_sub;

    logic        clk;
    logic        rst_n;
    logic [5:0]  alufn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        z;
    logic        v;
    logic        n;

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] es;
        logic        ez;
        logic        ev;
        logic        en;
    } vec_t;

    typedef struct packed {
        logic [31:0] s;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    localparam int NVEC = 11;
    vec_t tbl[NVEC];

    add_sub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .alufn (alufn),
        .a     (a),
        .b     (b),
        .s     (s),
        .z     (z),
        .v     (v),
        .n     (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact signed arithmetic in 64 bits, overflow = out of int32 range
    function automatic exp_t model(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        longint t;
        exp_t   e;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        t  = fn[0] ? (sx - sy) : (sx + sy);
        e.s = 32'(t);
        e.z = (e.s == 32'd0);
        e.v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        e.n = e.s[31];
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        tests_run++;
        if (s !== e.s || z !== e.z || v !== e.v || n !== e.n) begin
            tests_failed++;
            $display("FAIL %s: got s=%h z=%b v=%b n=%b, expected s=%h z=%b v=%b n=%b",
                     name, s, z, v, n, e.s, e.z, e.v, e.n);
        end
    endtask

    task automatic drive(input logic r, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        rst_n = r;
        alufn = fn;
        a     = x;
        b     = y;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    exp_t zero_e;
    exp_t e0;
    exp_t e1;
    exp_t prev;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [5:0]  rf;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        zero_e       = '{s: 32'h0, z: 1'b0, v: 1'b0, n: 1'b0};

        tbl[0]  = '{6'd0, 32'h55555555, 32'h55555555, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{6'd0, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{6'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{6'd3, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{6'd5, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'h80000001, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{6'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{6'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{6'd7, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{6'h3E, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{6'h3F, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{6'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0};

        // Reset with random operands for two cycles
        rst_n = 1'b0;
        alufn = 6'd0;
        a     = $urandom;
        b     = $urandom;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 6'($urandom), $urandom, $urandom);
            after_edge();
            check($sformatf("reset_%0d", i), zero_e);
        end
        drive(1'b0, 6'd1, 32'hxxxxxxxx, 32'hxxxxxxxx);
        after_edge();
        check("reset_x_inputs", zero_e);

        // Release: first result appears after exactly one edge
        drive(1'b1, 6'd0, 32'h00000010, 32'h00000020);
        #1;
        check("release_before_edge", zero_e);
        after_edge();
        check("release_first_result", model(6'd0, 32'h10, 32'h20));

        // Directed table, one vector per cycle
        for (int i = 0; i < NVEC; i++) begin
            drive(1'b1, tbl[i].fn, tbl[i].a, tbl[i].b);
            after_edge();
            check($sformatf("vec_%0d", i),
                  '{s: tbl[i].es, z: tbl[i].ez, v: tbl[i].ev, n: tbl[i].en});
        end

        // Back-to-back alternating ops; check old value before edge, new after
        e0 = '{s: 32'h80000000, z: 1'b0, v: 1'b0, n: 1'b1};
        e1 = '{s: 32'hFFFFFFFE, z: 1'b0, v: 1'b0, n: 1'b1};
        prev = '{s: tbl[NVEC-1].es, z: tbl[NVEC-1].ez, v: tbl[NVEC-1].ev, n: tbl[NVEC-1].en};
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(1'b1, 6'd1, 32'h80000001, 32'h00000001);
            else            drive(1'b1, 6'd7, 32'h00000003, 32'h00000005);
            #1;
            check($sformatf("b2b_hold_%0d", i), prev);
            after_edge();
            prev = (i % 2 == 0) ? e0 : e1;
            check($sformatf("b2b_%0d", i), prev);
        end

        // Reset in the middle of a stream discards the in-flight operation
        drive(1'b0, 6'd0, 32'h55555555, 32'h55555555);
        after_edge();
        check("reset_midstream", zero_e);
        drive(1'b1, 6'd1, 32'h00000005, 32'h00000007);
        after_edge();
        check("after_midreset", model(6'd1, 32'h5, 32'h7));

        // Random operations, biased toward sign-boundary operands
        for (int i = 0; i < 300; i++) begin
            rf = 6'($urandom);
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {ra[31], {31{~ra[31]}}};
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) == 1) ? ra : 32'hFFFFFFFF;
            drive(1'b1, rf, ra, rb);
            after_edge();
            check($sformatf("rand_%0d fn=%h a=%h b=%h", i, rf, ra, rb), model(rf, ra, rb));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
